// File: rtl/rv_divider.sv
// Iterative RISC-V integer divider: DIV/DIVU/REM/REMU plus RV64 *W forms, radix-2 restoring.
// Latency: N+2 cycles from accept to complete (N=32 or 64); divide-by-zero and signed overflow take 2.
// Backpressure: result held in WAIT_WB until wb_ack; ready low while busy, start_div ignored then.
// Ports: clk/reset (async active-low); start_div, op, is_word, srcA, srcB, rob_ptr_in, prf_ptr_in,
//        flush, wb_ack in; ready, complete, y, rob_ptr_out, prf_ptr_out out.
module rv_divider #(
  parameter int LG_W   = 6,
  parameter int LG_ROB = 6,
  parameter int LG_PRF = 7,
  localparam int W     = 1 << LG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_div,
  input  logic [1:0]        op,
  input  logic              is_word,
  input  logic [W-1:0]      srcA,
  input  logic [W-1:0]      srcB,
  input  logic [LG_ROB-1:0] rob_ptr_in,
  input  logic [LG_PRF-1:0] prf_ptr_in,
  input  logic              flush,
  input  logic              wb_ack,
  output logic              ready,
  output logic              complete,
  output logic [W-1:0]      y,
  output logic [LG_ROB-1:0] rob_ptr_out,
  output logic [LG_PRF-1:0] prf_ptr_out
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_PACK, S_WAIT_WB} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [W-1:0]        rem_q, rem_d;   // partial remainder
  logic [W-1:0]        dvs_q, dvs_d;   // divisor magnitude
  logic [W-1:0]        y_q, y_d;
  logic [LG_W:0]       cnt_q, cnt_d;
  logic                rem_sel_q, rem_sel_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                n32_q, n32_d;
  logic [LG_ROB-1:0]   rob_q, rob_d;
  logic [LG_PRF-1:0]   prf_q, prf_d;

  // Request decode: op[0]=1 means unsigned, op[1]=1 selects remainder.
  logic         req_signed;
  logic         req_n32;
  logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_mag, a_align;
  logic         a_neg, b_neg, req_dz, req_ovf;

  assign req_signed = ~op[0];
  assign req_n32    = is_word | (LG_W == 5);

  if (W == 64) begin : g_ext64
    assign a_ext = req_n32 ? {{(W-32){req_signed & srcA[31]}}, srcA[31:0]} : srcA;
    assign b_ext = req_n32 ? {{(W-32){req_signed & srcB[31]}}, srcB[31:0]} : srcB;
  end else begin : g_ext32
    assign a_ext = srcA;
    assign b_ext = srcB;
  end

  // After extension the MSB carries the sign of bit N-1 for signed ops.
  assign a_neg   = req_signed & a_ext[W-1];
  assign b_neg   = req_signed & b_ext[W-1];
  assign a_mag   = a_neg ? -a_ext : a_ext;
  assign b_mag   = b_neg ? -b_ext : b_ext;
  assign min_mag = req_n32 ? (W'(1) << 31) : (W'(1) << (W - 1));
  assign req_dz  = (b_ext == '0);
  assign req_ovf = a_neg & (a_mag == min_mag) & (b_ext == '1);
  // Left-align the dividend so its MSB is always at bit W-1; after N shifts
  // the quotient sits in the low N bits and the upper bits are zero.
  assign a_align = req_n32 ? (a_mag << (W - 32)) : a_mag;

  // One restoring step: W+1 bits is enough since the remainder stays below the divisor.
  logic [W:0] rem_sh, diff;
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // Result selection and sign fix-up for PACK.
  logic [W-1:0] res_sel, res_fix, res_out;
  assign res_sel = rem_sel_q ? rem_q : quo_q;
  assign res_fix = (rem_sel_q ? rneg_q : qneg_q) ? -res_sel : res_sel;

  if (W == 64) begin : g_pack64
    assign res_out = n32_q ? {{(W-32){res_fix[31]}}, res_fix[31:0]} : res_fix;
  end else begin : g_pack32
    assign res_out = res_fix;
  end

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    n32_d     = n32_q;
    rob_d     = rob_q;
    prf_d     = prf_q;

    case (state_q)
      S_IDLE: begin
        if (start_div && !flush) begin
          rem_sel_d = op[1];
          n32_d     = req_n32;
          rob_d     = rob_ptr_in;
          prf_d     = prf_ptr_in;
          if (req_dz) begin
            // Quotient all-ones, remainder is the dividend; no sign fix-up.
            quo_d   = '1;
            rem_d   = a_ext;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_PACK;
          end else if (req_ovf) begin
            quo_d   = a_ext;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_PACK;
          end else begin
            quo_d   = a_align;
            rem_d   = '0;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = req_n32 ? (LG_W+1)'(31) : (LG_W+1)'(W - 1);
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        if (!diff[W]) begin
          rem_d = diff[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - (LG_W+1)'(1);
        if (cnt_q == '0) state_d = S_PACK;
      end
      S_PACK: begin
        y_d     = res_out;
        state_d = S_WAIT_WB;
      end
      S_WAIT_WB: begin
        if (wb_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      n32_q     <= 1'b0;
      rob_q     <= '0;
      prf_q     <= '0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      n32_q     <= n32_d;
      rob_q     <= rob_d;
      prf_q     <= prf_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign complete    = (state_q == S_WAIT_WB);
  assign y           = y_q;
  assign rob_ptr_out = rob_q;
  assign prf_ptr_out = prf_q;

endmodule

// File: tb/tb_rv_divider.sv
// Directed bench for rv_divider (W=64): results, latency, bypasses, word forms,
// flush, writeback stall, asynchronous reset.
module tb_rv_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_div;
  logic [1:0]  op;
  logic        is_word;
  logic [63:0] srcA, srcB;
  logic [5:0]  rob_ptr_in;
  logic [6:0]  prf_ptr_in;
  logic        flush;
  logic        wb_ack;
  logic        ready;
  logic        complete;
  logic [63:0] y;
  logic [5:0]  rob_ptr_out;
  logic [6:0]  prf_ptr_out;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  always #5 clk = ~clk;

  rv_divider dut (
    .clk(clk), .reset(reset), .start_div(start_div), .op(op), .is_word(is_word),
    .srcA(srcA), .srcB(srcB), .rob_ptr_in(rob_ptr_in), .prf_ptr_in(prf_ptr_in),
    .flush(flush), .wb_ack(wb_ack), .ready(ready), .complete(complete), .y(y),
    .rob_ptr_out(rob_ptr_out), .prf_ptr_out(prf_ptr_out)
  );

  // Issue one request; lat counts rising edges from the accepting edge (=1)
  // until complete is seen, bounded at 200.
  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] rob, input logic [6:0] prf, input bit do_ack,
                        output int lat, output logic [63:0] yv);
    @(negedge clk);
    op = o; is_word = w; srcA = a; srcB = b; rob_ptr_in = rob; prf_ptr_in = prf; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    lat = 1;
    while (!complete && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    yv = y;
    if (do_ack) begin
      wb_ack = 1'b1;
      @(posedge clk); #1;
      wb_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_vec++; if (ready !== 1'b1)        begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_vec++; if (complete !== 1'b0)     begin n_err++; $display("FAIL reset_complete: got %b want 0", complete); end
    n_vec++; if (y !== 64'd0)           begin n_err++; $display("FAIL reset_y: got %h want 0", y); end
    n_vec++; if (rob_ptr_out !== 6'd0)  begin n_err++; $display("FAIL reset_rob: got %h want 0", rob_ptr_out); end
    n_vec++; if (prf_ptr_out !== 7'd0)  begin n_err++; $display("FAIL reset_prf: got %h want 0", prf_ptr_out); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] yv;
    run_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd5, 7'd9, 1'b1, lat, yv);
    n_vec++; if (lat !== 66) begin n_err++; $display("FAIL div_neg7_2_lat: got %0d want 66", lat); end
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_neg7_2: got %h want fffffffffffffffd", yv); end
    n_vec++; if (rob_ptr_out !== 6'd5) begin n_err++; $display("FAIL div_rob: got %h want 05", rob_ptr_out); end
    n_vec++; if (prf_ptr_out !== 7'd9) begin n_err++; $display("FAIL div_prf: got %h want 09", prf_ptr_out); end
    run_op(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd6, 7'd10, 1'b1, lat, yv);
    n_vec++; if (lat !== 66) begin n_err++; $display("FAIL rem_neg7_2_lat: got %0d want 66", lat); end
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rem_neg7_2: got %h want ffffffffffffffff", yv); end
    run_op(OP_DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 6'd1, 7'd1, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_7_neg2: got %h want fffffffffffffffd", yv); end
    run_op(OP_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 6'd1, 7'd1, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'd1) begin n_err++; $display("FAIL rem_7_neg2: got %h want 1", yv); end
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] yv;
    run_op(OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 6'd2, 7'd3, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'h0FFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_big: got %h want 0fffffffffffffff", yv); end
    run_op(OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 6'd2, 7'd3, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'hF) begin n_err++; $display("FAIL remu_big: got %h want f", yv); end
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] yv;
    run_op(OP_REMU, 1'b0, 64'd13, 64'd0, 6'd3, 7'd4, 1'b1, lat, yv);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL remu_dz_lat: got %0d want 2", lat); end
    n_vec++; if (yv !== 64'd13) begin n_err++; $display("FAIL remu_dz: got %h want d", yv); end
    run_op(OP_DIVU, 1'b0, 64'd13, 64'd0, 6'd3, 7'd4, 1'b1, lat, yv);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL divu_dz_lat: got %0d want 2", lat); end
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_dz: got %h want ffffffffffffffff", yv); end
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] yv;
    run_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd7, 7'd8, 1'b1, lat, yv);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL div_ovf_lat: got %0d want 2", lat); end
    n_vec++; if (yv !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL div_ovf: got %h want 8000000000000000", yv); end
    run_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd7, 7'd8, 1'b1, lat, yv);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rem_ovf_lat: got %0d want 2", lat); end
    n_vec++; if (yv !== 64'd0) begin n_err++; $display("FAIL rem_ovf: got %h want 0", yv); end
  endtask

  task automatic test_word();
    int lat; logic [63:0] yv;
    run_op(OP_DIV, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 6'd8, 7'd12, 1'b1, lat, yv);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL divw_lat: got %0d want 34", lat); end
    n_vec++; if (yv !== 64'hFFFF_FFFF_C000_0000) begin n_err++; $display("FAIL divw: got %h want ffffffffc0000000", yv); end
    run_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 6'd8, 7'd12, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'h0000_0000_5555_5550) begin n_err++; $display("FAIL divuw: got %h want 0000000055555550", yv); end
    run_op(OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 6'd8, 7'd12, 1'b1, lat, yv);
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL remw: got %h want ffffffffffffffff", yv); end
    run_op(OP_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'd8, 7'd12, 1'b1, lat, yv);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL divw_ovf_lat: got %0d want 2", lat); end
    n_vec++; if (yv !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divw_ovf: got %h want ffffffff80000000", yv); end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] yv; bit seen;
    @(negedge clk);
    op = OP_DIVU; is_word = 1'b0; srcA = 64'd100; srcB = 64'd7; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", ready); end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (complete) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_complete: got %b want 0", seen); end
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 6'd11, 7'd22, 1'b1, lat, yv);
    n_vec++; if (lat !== 66) begin n_err++; $display("FAIL post_flush_lat: got %0d want 66", lat); end
    n_vec++; if (yv !== 64'd14) begin n_err++; $display("FAIL post_flush_divu: got %h want e", yv); end
    // flush beats wb_ack in WAIT_WB, and beats start_div in IDLE
    run_op(OP_REMU, 1'b0, 64'd100, 64'd7, 6'd11, 7'd22, 1'b0, lat, yv);
    n_vec++; if (yv !== 64'd2) begin n_err++; $display("FAIL remu_100_7: got %h want 2", yv); end
    @(negedge clk); flush = 1'b1; wb_ack = 1'b1;
    @(posedge clk); #1; flush = 1'b0; wb_ack = 1'b0;
    n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL flush_wait_complete: got %b want 0", complete); end
    @(negedge clk); flush = 1'b1; start_div = 1'b1;
    @(posedge clk); #1; flush = 1'b0; start_div = 1'b0;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL flush_start_ready: got %b want 1", ready); end
  endtask

  task automatic test_wb_stall();
    int lat; logic [63:0] yv;
    run_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd33, 7'd99, 1'b0, lat, yv);
    n_vec++; if (yv !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL stall_y0: got %h want fffffffffffffffd", yv); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_div = 1'b1; op = OP_DIVU; srcA = 64'd50 + 64'(i); srcB = 64'd0; rob_ptr_in = 6'(i); prf_ptr_in = 7'(i);
      @(posedge clk); #1;
      n_vec++; if (complete !== 1'b1) begin n_err++; $display("FAIL stall_complete[%0d]: got %b want 1", i, complete); end
      n_vec++; if (y !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL stall_y[%0d]: got %h want fffffffffffffffd", i, y); end
      n_vec++; if (rob_ptr_out !== 6'd33 || prf_ptr_out !== 7'd99) begin n_err++; $display("FAIL stall_tags[%0d]: got %h/%h want 21/63", i, rob_ptr_out, prf_ptr_out); end
    end
    @(negedge clk); start_div = 1'b0; wb_ack = 1'b1;
    @(posedge clk); #1; wb_ack = 1'b0;
    n_vec++; if (ready !== 1'b1 || complete !== 1'b0) begin n_err++; $display("FAIL stall_release: got ready=%b complete=%b want 1/0", ready, complete); end
    // wb_ack while idle has no effect
    @(negedge clk); wb_ack = 1'b1;
    @(posedge clk); #1; wb_ack = 1'b0;
    n_vec++; if (ready !== 1'b1 || complete !== 1'b0) begin n_err++; $display("FAIL idle_ack: got ready=%b complete=%b want 1/0", ready, complete); end
  endtask

  task automatic test_async_reset();
    int lat; logic [63:0] yv;
    @(negedge clk);
    op = OP_DIV; is_word = 1'b0; srcA = 64'd1000; srcB = 64'd3; rob_ptr_in = 6'd44; prf_ptr_in = 7'd55; start_div = 1'b1;
    @(posedge clk); #1; start_div = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_vec++; if (y !== 64'd0) begin n_err++; $display("FAIL areset_y: got %h want 0", y); end
    n_vec++; if (rob_ptr_out !== 6'd0 || prf_ptr_out !== 7'd0) begin n_err++; $display("FAIL areset_tags: got %h/%h want 0/0", rob_ptr_out, prf_ptr_out); end
    n_vec++; if (complete !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL areset_state: got complete=%b ready=%b want 0/1", complete, ready); end
    @(negedge clk); reset = 1'b1;
    run_op(OP_DIV, 1'b0, 64'd1000, 64'd3, 6'd44, 7'd55, 1'b1, lat, yv);
    n_vec++; if (lat !== 66 || yv !== 64'd333) begin n_err++; $display("FAIL post_reset_div: got lat=%0d y=%h want 66/14d", lat, yv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_div = 1'b0; op = 2'b00; is_word = 1'b0; srcA = '0; srcB = '0;
    rob_ptr_in = '0; prf_ptr_in = '0; flush = 1'b0; wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b1;
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_word();
    test_flush();
    test_wb_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
